return_addr_stack: RTL

//  Parametrised return-address stack (RAS) for the ID stage; successor of the fixed 32x32 PC stack.

---
 rtl/return_addr_stack.sv | 110 +++++++++++
 1 files changed

// File: rtl/return_addr_stack.sv
// Return-address stack for the ID stage: push on call, registered top-of-stack for return targets.
// Define RAS_WRAP_EN to accept a push while full as a circular overwrite of the oldest entry.
module return_addr_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] top,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  underflow
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_TWO  = PTR_W'(2);

  // push/pop are single-cycle commands sampled on every posedge without hold/flush;
  // there is no ready: an impossible request is reported by the overflow/underflow pulses.

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  sp, sp_n;
  logic [CNT_W-1:0]  count_n;
  logic [DATA_W-1:0] top_n;
  logic              ovf_n, unf_n;
  logic              we;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign rd_idx = sp - PTR_TWO;

  always_comb begin
    sp_n    = sp;
    count_n = count;
    top_n   = top;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    we      = 1'b0;
    wr_idx  = sp;
    if (push && pop && !empty) begin
      // Replace: the return is consumed and the new call lands in the same slot.
      we     = 1'b1;
      wr_idx = sp - PTR_ONE;
      top_n  = data_in;
    end else if (push) begin
      if (!full) begin
        we      = 1'b1;
        sp_n    = sp + PTR_ONE;
        count_n = count + CNT_ONE;
        top_n   = data_in;
      end else begin
        ovf_n = 1'b1;
`ifdef RAS_WRAP_EN
        we    = 1'b1;
        sp_n  = sp + PTR_ONE;
        top_n = data_in;
`endif
      end
    end else if (pop) begin
      if (empty) begin
        unf_n = 1'b1;
      end else begin
        sp_n    = sp - PTR_ONE;
        count_n = count - CNT_ONE;
        top_n   = (count == CNT_ONE) ? '0 : mem[rd_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      sp        <= '0;
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!hold) begin
      sp        <= sp_n;
      count     <= count_n;
      top       <= top_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
    end
  end

  // Storage is intentionally not reset; count/sp define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!rst && !flush && !hold && we) mem[wr_idx] <= data_in;
  end

endmodule
